// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM states and instruction field positions.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } fetch_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JT_MSB     = 25;
    localparam int JT_LSB     = 0;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode-side presentation.
interface inst_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic        inst_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        jump;
    logic [31:0] retired_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, opcode, rs, rt, rd, funct, imm16, jtarget,
        output pc_out, pc_plus4, retired_cnt,
        input  inst_ready, branch_taken, jump
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, opcode, rs, rt, rd, funct, imm16, jtarget,
        input  pc_out, pc_plus4, retired_cnt,
        output inst_ready, branch_taken, jump
    );

endinterface

// File: rtl/pc_next_calc.sv
// Redirect logic: picks the PC following a retiring instruction (jump over branch over sequential).
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic        branch_taken,
    input  logic        jump,
    output logic [31:0] next_pc
);

    // Priority select; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jtarget, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset(imm16);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory, presents fields to decode.
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         req_q, req_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    pc_next_calc u_pc_next_calc (
        .pc_plus4     (pc_plus4),
        .imm16        (ir_q[IMM_MSB:IMM_LSB]),
        .jtarget      (ir_q[JT_MSB:JT_LSB]),
        .branch_taken (bus.branch_taken),
        .jump         (bus.jump),
        .next_pc      (next_pc)
    );

    // Next-state logic; req is gated so acks during the first post-reset cycle are ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (req_q && bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_ISSUE;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.inst_ready) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (!rst) begin
            state_d = S_FETCH;
            pc_d    = RESET_PC;
            ir_d    = '0;
            cnt_d   = '0;
            req_d   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        ir_q    <= ir_d;
        req_q   <= req_d;
        cnt_q   <= cnt_d;
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.inst_valid  = (state_q == S_ISSUE);
    assign bus.opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.rs          = ir_q[RS_MSB:RS_LSB];
    assign bus.rt          = ir_q[RT_MSB:RT_LSB];
    assign bus.rd          = ir_q[RD_MSB:RD_LSB];
    assign bus.funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign bus.imm16       = ir_q[IMM_MSB:IMM_LSB];
    assign bus.jtarget     = ir_q[JT_MSB:JT_LSB];
    assign bus.pc_out      = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.retired_cnt = cnt_q;

endmodule
